hamming_decode_arbiter: RTL and testbench

- Round-robin scheduler that shares one combinational SECDED (8,4) Hamming decoder between two requesters.
- Accepts codewords over valid/ready handshakes and sequences each one through the decoder.
- Registers the corrected nibble, source ID and error flags toward a single back-pressured consumer.
- Optionally keeps saturating error-statistics counters; sits between the codeword sources and the downstream data sink.

---
 rtl/hamming_decode_arbiter_pkg.sv | 45 ++++
 rtl/hamming_decode_arbiter_if.sv | 32 +++
 rtl/hamming_decode_arbiter_secded_decode.sv | 36 +++
 rtl/hamming_decode_arbiter.sv | 175 +++++++++++++++++
 tb/tb_hamming_decode_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hamming_decode_arbiter_pkg.sv
// hamming_pkg: shared widths, FSM state type, data bit positions and the
// SECDED (8,4) helper functions used by the decoder.
//   CW_W / DATA_W : codeword and data nibble widths
//   state_t       : arbiter FSM states IDLE, DECODE, OUT
//   syndrome()    : XOR of the indices of all set codeword bits
//   overall_par() : XOR of all codeword bits
//   data_of()     : extract the data nibble {c[7],c[6],c[5],c[3]}
package hamming_pkg;

  localparam int CW_W   = 8;
  localparam int DATA_W = 4;

  localparam int D0_POS = 3;
  localparam int D1_POS = 5;
  localparam int D2_POS = 6;
  localparam int D3_POS = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    OUT    = 2'd2
  } state_t;

  function automatic logic [2:0] syndrome(input logic [CW_W-1:0] cw);
    logic [2:0] s;
    s = 3'd0;
    for (int i = 0; i < CW_W; i++) begin
      if (cw[i]) begin
        s = s ^ 3'(i);
      end else begin
        s = s;
      end
    end
    return s;
  endfunction

  function automatic logic overall_par(input logic [CW_W-1:0] cw);
    return ^cw;
  endfunction

  function automatic logic [DATA_W-1:0] data_of(input logic [CW_W-1:0] cw);
    return {cw[D3_POS], cw[D2_POS], cw[D1_POS], cw[D0_POS]};
  endfunction

endpackage

// File: rtl/hamming_decode_arbiter_if.sv
// hamming_decode_arbiter_if: groups the two requester handshakes and the
// back-pressured result channel.
//   req_valid/req_cw0/req_cw1/req_ready : codeword inputs, one lane per requester
//   out_valid/out_ready                 : result handshake
//   out_data/out_cw/out_src/out_sec/out_ded : decoded result fields
// slave modport is the arbiter's view, master is the sources/sink view.
interface hamming_decode_arbiter_if;
  import hamming_pkg::*;

  logic [1:0]        req_valid;
  logic [CW_W-1:0]   req_cw0;
  logic [CW_W-1:0]   req_cw1;
  logic [1:0]        req_ready;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CW_W-1:0]   out_cw;
  logic              out_src;
  logic              out_sec;
  logic              out_ded;

  modport slave (
    input  req_valid, req_cw0, req_cw1, out_ready,
    output req_ready, out_valid, out_data, out_cw, out_src, out_sec, out_ded
  );

  modport master (
    output req_valid, req_cw0, req_cw1, out_ready,
    input  req_ready, out_valid, out_data, out_cw, out_src, out_sec, out_ded
  );

endinterface

// File: rtl/hamming_decode_arbiter_secded_decode.sv
// hamming_secded_decode: purely combinational SECDED (8,4) decoder.
//   cw     in  : received codeword
//   cw_fix out : corrected codeword (unchanged on clean or double error)
//   data   out : data nibble taken from cw_fix
//   sec    out : single error corrected (overall parity odd)
//   ded    out : double error detected (syndrome nonzero, parity even)
module hamming_secded_decode
  import hamming_pkg::*;
(
  input  logic [CW_W-1:0]   cw,
  output logic [CW_W-1:0]   cw_fix,
  output logic [DATA_W-1:0] data,
  output logic              sec,
  output logic              ded
);

  logic [2:0] syn;
  logic       par;

  // Syndrome/parity evaluation and single-bit correction.
  always_comb begin
    syn = syndrome(cw);
    par = overall_par(cw);
    sec = par;
    ded = (syn != 3'd0) && !par;
    // Syndrome 0 with odd parity means the overall parity bit c[0] itself
    // flipped, so shifting by the syndrome covers that case too.
    if (par) begin
      cw_fix = cw ^ ({{(CW_W-1){1'b0}}, 1'b1} << syn);
    end else begin
      cw_fix = cw;
    end
    data = data_of(cw_fix);
  end

endmodule

// File: rtl/hamming_decode_arbiter.sv
// hamming_decode_arbiter: round-robin share of one SECDED (8,4) decoder
// between two requesters, with a registered, back-pressured result.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : hamming_decode_arbiter_if.slave (requests and result)
//   cnt_clr    : synchronous clear of the error counters
//   sec_cnt0/1 : saturating single-error count per requester
//   ded_cnt    : saturating double-error count, both requesters
// Optional feature macro HAMMING_ERR_CNT_EN builds the counters; without it
// the counter outputs are tied to 0 and cnt_clr is ignored.
module hamming_decode_arbiter
  import hamming_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  hamming_decode_arbiter_if.slave  bus,
  input  logic                     cnt_clr,
  output logic [CNT_W-1:0]         sec_cnt0,
  output logic [CNT_W-1:0]         sec_cnt1,
  output logic [CNT_W-1:0]         ded_cnt
);

  state_t            state;
  state_t            next_state;
  logic              last;
  logic              grant;
  logic              take;
  logic [CW_W-1:0]   cap_cw;
  logic              cap_src;

  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic [CW_W-1:0]   res_cw;
  logic              res_src;
  logic              res_sec;
  logic              res_ded;

  logic [CW_W-1:0]   dec_cw;
  logic [DATA_W-1:0] dec_data;
  logic              dec_sec;
  logic              dec_ded;

  hamming_secded_decode u_dec (
    .cw     (cap_cw),
    .cw_fix (dec_cw),
    .data   (dec_data),
    .sec    (dec_sec),
    .ded    (dec_ded)
  );

  // Grant selection, ready generation and next-state logic.
  always_comb begin
    next_state    = state;
    grant         = 1'b0;
    take          = 1'b0;
    bus.req_ready = 2'b00;
    case (state)
      IDLE: begin
        // A tie goes to the requester that was not served last; a lone
        // requester is always granted.
        if (bus.req_valid == 2'b11) begin
          grant = ~last;
        end else if (bus.req_valid[1]) begin
          grant = 1'b1;
        end else begin
          grant = 1'b0;
        end
        if (bus.req_valid != 2'b00) begin
          take          = 1'b1;
          bus.req_ready = grant ? 2'b10 : 2'b01;
          next_state    = DECODE;
        end else begin
          take = 1'b0;
        end
      end
      DECODE: next_state = OUT;
      OUT: begin
        if (bus.out_ready) begin
          next_state = IDLE;
        end else begin
          next_state = OUT;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State, capture and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      cap_cw    <= {CW_W{1'b0}};
      cap_src   <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= {DATA_W{1'b0}};
      res_cw    <= {CW_W{1'b0}};
      res_src   <= 1'b0;
      res_sec   <= 1'b0;
      res_ded   <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (take) begin
            cap_cw  <= grant ? bus.req_cw1 : bus.req_cw0;
            cap_src <= grant;
            last    <= grant;
          end
        end
        DECODE: begin
          res_valid <= 1'b1;
          res_data  <= dec_data;
          res_cw    <= dec_cw;
          res_src   <= cap_src;
          res_sec   <= dec_sec;
          res_ded   <= dec_ded;
        end
        OUT: begin
          if (bus.out_ready) begin
            res_valid <= 1'b0;
          end
        end
        default: res_valid <= 1'b0;
      endcase
    end
  end

  assign bus.out_valid = res_valid;
  assign bus.out_data  = res_data;
  assign bus.out_cw    = res_cw;
  assign bus.out_src   = res_src;
  assign bus.out_sec   = res_sec;
  assign bus.out_ded   = res_ded;

`ifdef HAMMING_ERR_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] sec0;
  logic [CNT_W-1:0] sec1;
  logic [CNT_W-1:0] dedc;

  // Saturating error counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      sec0 <= {CNT_W{1'b0}};
      sec1 <= {CNT_W{1'b0}};
      dedc <= {CNT_W{1'b0}};
    end else if (state == DECODE) begin
      if (dec_sec && !cap_src && (sec0 != CNT_MAX)) begin
        sec0 <= sec0 + CNT_ONE;
      end
      if (dec_sec && cap_src && (sec1 != CNT_MAX)) begin
        sec1 <= sec1 + CNT_ONE;
      end
      if (dec_ded && (dedc != CNT_MAX)) begin
        dedc <= dedc + CNT_ONE;
      end
    end
  end

  assign sec_cnt0 = sec0;
  assign sec_cnt1 = sec1;
  assign ded_cnt  = dedc;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign sec_cnt0 = {CNT_W{1'b0}};
  assign sec_cnt1 = {CNT_W{1'b0}};
  assign ded_cnt  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hamming_decode_arbiter.sv
// Testbench for hamming_decode_arbiter: scoreboard of expected decoder
// results, pushed at each input transfer and popped when a result is
// accepted downstream, plus per-scenario inline checks.
module tb_hamming_decode_arbiter;

`ifdef HAMMING_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    logic       src;
    logic [7:0] cw;
    logic [3:0] data;
    logic       sec;
    logic       ded;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       cnt_clr;
  logic [7:0] sec_cnt0;
  logic [7:0] sec_cnt1;
  logic [7:0] ded_cnt;

  int   n_tests;
  int   n_fail;
  exp_t q[$];
  bit   model_last;
  int   m_sec0;
  int   m_sec1;
  int   m_ded;

  hamming_decode_arbiter_if bus();

  hamming_decode_arbiter #(.CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .cnt_clr  (cnt_clr),
    .sec_cnt0 (sec_cnt0),
    .sec_cnt1 (sec_cnt1),
    .ded_cnt  (ded_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input bit src, input logic [7:0] c);
    exp_t e;
    int   s;
    bit   p;
    logic [7:0] f;
    s = 0;
    p = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) begin
        s = s ^ i;
        p = ~p;
      end
    end
    f = c;
    if (p) f[s] = ~f[s];
    e.src  = src;
    e.cw   = f;
    e.data = {f[7], f[6], f[5], f[3]};
    e.sec  = p;
    e.ded  = !p && (s != 0);
    return e;
  endfunction

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic void push_exp(input bit src, input logic [7:0] cw, input bit clr);
    exp_t e;
    e = model(src, cw);
    q.push_back(e);
    if (clr) begin
      m_sec0 = 0;
      m_sec1 = 0;
      m_ded  = 0;
    end else begin
      if (e.sec && !src) m_sec0 = sat(m_sec0 + 1);
      if (e.sec && src)  m_sec1 = sat(m_sec1 + 1);
      if (e.ded)         m_ded  = sat(m_ded + 1);
    end
  endfunction

  // Scoreboard: compare every accepted result with the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected got cw=%h src=%0d with empty queue", bus.out_cw, bus.out_src);
      end else begin
        e = q.pop_front();
        if (bus.out_src !== e.src || bus.out_cw !== e.cw || bus.out_data !== e.data ||
            bus.out_sec !== e.sec || bus.out_ded !== e.ded) begin
          n_fail++;
          $display("FAIL sb_result got src=%0d cw=%h data=%h sec=%0d ded=%0d want src=%0d cw=%h data=%h sec=%0d ded=%0d",
                   bus.out_src, bus.out_cw, bus.out_data, bus.out_sec, bus.out_ded,
                   e.src, e.cw, e.data, e.sec, e.ded);
        end
        n_tests++;
        if (sec_cnt0 !== 8'(CNT_EN ? m_sec0 : 0) || sec_cnt1 !== 8'(CNT_EN ? m_sec1 : 0) ||
            ded_cnt !== 8'(CNT_EN ? m_ded : 0)) begin
          n_fail++;
          $display("FAIL sb_counters got %0d/%0d/%0d want %0d/%0d/%0d", sec_cnt0, sec_cnt1, ded_cnt,
                   CNT_EN ? m_sec0 : 0, CNT_EN ? m_sec1 : 0, CNT_EN ? m_ded : 0);
        end
      end
    end
  end

  task automatic send(input bit src, input logic [7:0] cw, input bit push, input bit clr);
    bit done;
    done = 1'b0;
    @(posedge clk); #1;
    if (src) bus.req_cw1 = cw; else bus.req_cw0 = cw;
    bus.req_valid[src] = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (bus.req_ready[src]) done = 1'b1;
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL send_timeout src=%0d got no ready, want ready within 100 cycles", src);
      bus.req_valid[src] = 1'b0;
    end else begin
      if (push) push_exp(src, cw, clr);
      model_last = src;
      @(posedge clk); #1;
      bus.req_valid[src] = 1'b0;
      if (clr) begin
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
      end
    end
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (q.size() == 0 && !bus.out_valid) done = 1'b1;
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL drain_timeout got %0d pending, want 0", q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (bus.req_ready !== 2'b00 || bus.out_valid !== 1'b0 || bus.out_data !== 4'h0 ||
        bus.out_cw !== 8'h00 || bus.out_src !== 1'b0 || bus.out_sec !== 1'b0 || bus.out_ded !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got rdy=%b v=%b d=%h cw=%h src=%b sec=%b ded=%b want all 0",
               bus.req_ready, bus.out_valid, bus.out_data, bus.out_cw, bus.out_src, bus.out_sec, bus.out_ded);
    end
    n_tests++;
    if (sec_cnt0 !== 8'h00 || sec_cnt1 !== 8'h00 || ded_cnt !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_counters got %0d/%0d/%0d want 0/0/0", sec_cnt0, sec_cnt1, ded_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_last = 1'b1;
    m_sec0 = 0; m_sec1 = 0; m_ded = 0;
  endtask

  task automatic test_clean();
    send(1'b0, 8'hAA, 1'b1, 1'b0);
    @(negedge clk);
    n_tests++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_n1 got out_valid=%b want 0", bus.out_valid);
    end
    @(negedge clk);
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 4'hB) begin
      n_fail++;
      $display("FAIL latency_n2 got out_valid=%b data=%h want 1 and B", bus.out_valid, bus.out_data);
    end
    wait_drain();
  endtask

  task automatic test_single();
    send(1'b1, 8'h8A, 1'b1, 1'b0);
    wait_drain();
    n_tests++;
    if (sec_cnt1 !== 8'(CNT_EN ? 1 : 0)) begin
      n_fail++;
      $display("FAIL single_sec_cnt1 got %0d want %0d", sec_cnt1, CNT_EN ? 1 : 0);
    end
    send(1'b0, 8'hAB, 1'b1, 1'b0);
    wait_drain();
  endtask

  task automatic test_double();
    send(1'b0, 8'hAC, 1'b1, 1'b0);
    wait_drain();
    n_tests++;
    if (ded_cnt !== 8'(CNT_EN ? 1 : 0)) begin
      n_fail++;
      $display("FAIL double_ded_cnt got %0d want %0d", ded_cnt, CNT_EN ? 1 : 0);
    end
  endtask

  task automatic test_arbitration();
    bit         done;
    bit         g;
    logic [7:0] cw;
    @(posedge clk); #1;
    bus.req_cw0   = 8'(($urandom));
    bus.req_cw1   = 8'(($urandom));
    bus.req_valid = 2'b11;
    for (int n = 0; n < 8; n++) begin
      done = 1'b0;
      for (int k = 0; k < 50 && !done; k++) begin
        @(negedge clk);
        if (bus.req_ready != 2'b00) done = 1'b1;
      end
      g = ~model_last;
      n_tests++;
      if (!done || bus.req_ready !== (g ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL arb_grant n=%0d got ready=%b want %b", n, bus.req_ready, g ? 2'b10 : 2'b01);
      end
      cw = g ? bus.req_cw1 : bus.req_cw0;
      push_exp(g, cw, 1'b0);
      model_last = g;
      @(posedge clk); #1;
      if (g) bus.req_cw1 = 8'(($urandom)); else bus.req_cw0 = 8'(($urandom));
    end
    bus.req_valid = 2'b00;
    wait_drain();
  endtask

  task automatic test_backpressure();
    exp_t e;
    bit   done;
    e = model(1'b0, 8'h8A);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(1'b0, 8'h8A, 1'b1, 1'b0);
    bus.req_cw1      = 8'h6C;
    bus.req_valid[1] = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (bus.out_valid) done = 1'b1;
    end
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_cw !== e.cw || bus.out_data !== e.data ||
          bus.out_src !== e.src || bus.out_sec !== e.sec || bus.req_ready !== 2'b00) begin
        n_fail++;
        $display("FAIL bp_hold c=%0d got v=%b cw=%h d=%h src=%b sec=%b rdy=%b want 1 %h %h %b %b 00",
                 c, bus.out_valid, bus.out_cw, bus.out_data, bus.out_src, bus.out_sec, bus.req_ready,
                 e.cw, e.data, e.src, e.sec);
      end
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (bus.req_ready[1]) done = 1'b1;
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL bp_followup got no ready for requester 1, want ready");
      bus.req_valid[1] = 1'b0;
    end else begin
      push_exp(1'b1, 8'h6C, 1'b0);
      model_last = 1'b1;
      @(posedge clk); #1;
      bus.req_valid[1] = 1'b0;
    end
    wait_drain();
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 260; n++) begin
      send(1'b0, (n % 2 == 0) ? 8'hAB : 8'h2A, 1'b1, 1'b0);
    end
    wait_drain();
    n_tests++;
    if (sec_cnt0 !== (CNT_EN ? 8'hFF : 8'h00)) begin
      n_fail++;
      $display("FAIL sat_sec_cnt0 got %h want %h", sec_cnt0, CNT_EN ? 8'hFF : 8'h00);
    end
  endtask

  task automatic test_reset_mid();
    send(1'b0, 8'hAB, 1'b0, 1'b0);
    rst              = 1'b1;
    bus.req_cw0      = 8'hAA;
    bus.req_valid    = 2'b01;
    @(posedge clk); #1;
    rst = 1'b0;
    model_last = 1'b1;
    m_sec0 = 0; m_sec1 = 0; m_ded = 0;
    @(negedge clk);
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.req_ready !== 2'b01 || sec_cnt0 !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_mid got v=%b rdy=%b sec_cnt0=%h want 0 01 00",
               bus.out_valid, bus.req_ready, sec_cnt0);
    end
    push_exp(1'b0, 8'hAA, 1'b0);
    model_last = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    wait_drain();
  endtask

  task automatic test_clear();
    send(1'b0, 8'hAB, 1'b1, 1'b0);
    send(1'b1, 8'hAC, 1'b1, 1'b0);
    wait_drain();
    send(1'b0, 8'hAB, 1'b1, 1'b1);
    wait_drain();
    n_tests++;
    if (sec_cnt0 !== 8'h00 || sec_cnt1 !== 8'h00 || ded_cnt !== 8'h00) begin
      n_fail++;
      $display("FAIL clear_priority got %0d/%0d/%0d want 0/0/0", sec_cnt0, sec_cnt1, ded_cnt);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish, want finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    model_last    = 1'b1;
    m_sec0        = 0;
    m_sec1        = 0;
    m_ded         = 0;
    rst           = 1'b1;
    cnt_clr       = 1'b0;
    bus.req_valid = 2'b00;
    bus.req_cw0   = 8'h00;
    bus.req_cw1   = 8'h00;
    bus.out_ready = 1'b1;
    test_reset();
    test_clean();
    test_single();
    test_double();
    test_arbitration();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    test_clear();
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover got %0d pending, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
